// File: rtl/sevenseg_pkg.sv
// Shared segment codes for the seven-segment scanner: gfedcba patterns, active-low.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = SEG_0;
      4'h1:    code = SEG_1;
      4'h2:    code = SEG_2;
      4'h3:    code = SEG_3;
      4'h4:    code = SEG_4;
      4'h5:    code = SEG_5;
      4'h6:    code = SEG_6;
      4'h7:    code = SEG_7;
      4'h8:    code = SEG_8;
      4'h9:    code = SEG_9;
      4'hA:    code = SEG_A;
      4'hB:    code = SEG_B;
      4'hC:    code = SEG_C;
      4'hD:    code = SEG_D;
      4'hE:    code = SEG_E;
      default: code = SEG_F;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex nibble to active-low gfedcba segment code.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  assign code = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode seven-segment scanner with PWM dimming and a frame-synchronous
// double-buffered load port. Define SEVENSEG_SCAN_BLINK_EN to add per-digit blinking.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV_W    = 17,
  parameter int BR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_mask_i,
  input  logic [N_DIGITS-1:0]   blank_i,
`ifdef SEVENSEG_SCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_i,
`endif
  input  logic                  load_i,
  input  logic [BR_W-1:0]       brightness_i,
  output logic                  busy_o,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp
);

  localparam int IDX_W = $clog2(N_DIGITS);

  logic [DIV_W-1:0]      presc;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] pend_digits, act_digits;
  logic [N_DIGITS-1:0]   pend_dp, act_dp, pend_blank, act_blank, blink_hide;
  logic                  slot_end, frame_end, lit;
  logic [BR_W-1:0]       phase;
  logic [3:0]            sel_nib;
  logic                  sel_dp, sel_blank;
  logic [N_DIGITS-1:0]   sel_an;
  logic [6:0]            sel_code;

  assign slot_end  = &presc;
  assign frame_end = slot_end && (idx == IDX_W'(N_DIGITS - 1));
  assign phase     = presc[DIV_W-1 -: BR_W];
  assign lit       = (&brightness_i) || (phase < brightness_i);

`ifdef SEVENSEG_SCAN_BLINK_EN
  logic [N_DIGITS-1:0] pend_blink, act_blink;
  logic [5:0]          frame_cnt;
  assign blink_hide = frame_cnt[5] ? act_blink : '0;
`else
  assign blink_hide = '0;
`endif

  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    sel_an    = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_nib   = act_digits[4*k +: 4];
        sel_dp    = act_dp[k];
        sel_blank = act_blank[k] | blink_hide[k];
        sel_an[k] = 1'b0;
      end
    end
  end

  sevenseg_decode u_decode (
    .nibble (sel_nib),
    .code   (sel_code)
  );

  // load_i is a one-cycle strobe with no back-pressure: it always overwrites pending
  // and sets busy_o; busy_o clears only when pending moves to active at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '1;
      busy_o      <= 1'b0;
      seg         <= SEG_OFF;
      an          <= '1;
      dp          <= 1'b1;
`ifdef SEVENSEG_SCAN_BLINK_EN
      pend_blink  <= '0;
      act_blink   <= '0;
      frame_cnt   <= '0;
`endif
    end else begin
      presc <= presc + DIV_W'(1);
      if (slot_end) idx <= frame_end ? '0 : idx + IDX_W'(1);

      if (frame_end && busy_o) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
`ifdef SEVENSEG_SCAN_BLINK_EN
        act_blink  <= pend_blink;
`endif
      end
      if (load_i) begin
        pend_digits <= digits_i;
        pend_dp     <= dp_mask_i;
        pend_blank  <= blank_i;
`ifdef SEVENSEG_SCAN_BLINK_EN
        pend_blink  <= blink_i;
`endif
        busy_o      <= 1'b1;
      end else if (frame_end) begin
        busy_o <= 1'b0;
      end
`ifdef SEVENSEG_SCAN_BLINK_EN
      if (frame_end) frame_cnt <= frame_cnt + 6'd1;
`endif

      if (lit && !sel_blank) begin
        an  <= sel_an;
        seg <= sel_code;
        dp  <= ~sel_dp;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: random loads and brightness against a frame-level reference
// model; expected outputs are queued per cycle and compared by an independent monitor.
module tb_sevenseg_scan;

  localparam int N_DIGITS = 4;
  localparam int DIV_W    = 4;
  localparam int BR_W     = 2;
  localparam int SLOT     = 1 << DIV_W;
  localparam int FRAME    = N_DIGITS * SLOT;
  localparam int BR_MAX   = (1 << BR_W) - 1;

  typedef struct {
    int          cyc;
    logic [15:0] digits;
    logic [3:0]  dpm;
    logic [3:0]  blank;
  } load_t;

  typedef struct packed {
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     digits_i;
  logic [3:0]      dp_mask_i, blank_i;
  logic            load_i;
  logic [BR_W-1:0] brightness_i;
  logic            busy_o, dp;
  logic [6:0]      seg;
  logic [3:0]      an;

  logic [12:0] exp_q[$];
  load_t       load_q[$];
  int          cyc;
  bit          run;
  int          checks, errors;
  logic [6:0]  seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevenseg_scan #(.N_DIGITS(N_DIGITS), .DIV_W(DIV_W), .BR_W(BR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digits_i     (digits_i),
    .dp_mask_i    (dp_mask_i),
    .blank_i      (blank_i),
    .load_i       (load_i),
    .brightness_i (brightness_i),
    .busy_o       (busy_o),
    .seg          (seg),
    .an           (an),
    .dp           (dp)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model: outputs seen in cycle c+1 given everything up to cycle c.
  // Boundaries are cycles with c % FRAME == FRAME-1; a load at cycle L reaches the
  // display buffer at the first boundary B with L < B, and is shown from B+1 onward.
  function automatic logic [12:0] predict(input int c);
    int          digit, phase, a, bmax, l, nb;
    bit          lit;
    logic [15:0] dg;
    logic [3:0]  dpm, blank;
    out_t        o;
    digit = (c / SLOT) % N_DIGITS;
    phase = (c % SLOT) / (SLOT >> BR_W);
    a     = -1;
    if (c >= FRAME) begin
      bmax = ((c - FRAME) / FRAME) * FRAME + FRAME - 1;
      foreach (load_q[i]) if (load_q[i].cyc < bmax) a = i;
    end
    dg = '0; dpm = '0; blank = 4'hF;
    if (a >= 0) begin
      dg = load_q[a].digits; dpm = load_q[a].dpm; blank = load_q[a].blank;
    end
    o.busy = 1'b0;
    if (load_q.size() > 0) begin
      l  = load_q[load_q.size()-1].cyc;
      nb = (l / FRAME) * FRAME + FRAME - 1;
      if (nb <= l) nb += FRAME;
      o.busy = (nb > c);
    end
    lit = (int'(brightness_i) == BR_MAX) || (phase < int'(brightness_i));
    if (lit && !blank[digit]) begin
      o.an  = 4'hF ^ (4'b0001 << digit);
      o.seg = seg_lut[dg[4*digit +: 4]];
      o.dp  = ~dpm[digit];
    end else begin
      o.an = 4'hF; o.seg = 7'h7F; o.dp = 1'b1;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    #2;
    if (run && rst_n) exp_q.push_back(predict(cyc));
  end

  // scoreboard monitor
  always @(negedge clk) begin
    out_t got, e;
    if (run && rst_n) begin
      got = {busy_o, an, seg, dp};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow cycle %0d: no expectation queued", cyc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out cycle %0d: got busy=%b an=%h seg=%h dp=%b, expected busy=%b an=%h seg=%h dp=%b",
                   cyc, got.busy, got.an, got.seg, got.dp, e.busy, e.an, e.seg, e.dp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
    load_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic load_now(input logic [15:0] d, input logic [3:0] m, input logic [3:0] b);
    load_t r;
    load_i = 1'b1; digits_i = d; dp_mask_i = m; blank_i = b;
    r.cyc = cyc; r.digits = d; r.dpm = m; r.blank = b;
    load_q.push_back(r);
  endtask

  task automatic wait_phase(input int p);
    while (cyc % FRAME != p) next_cycle();
  endtask

  task automatic release_reset();
    out_t r;
    r.busy = 1'b0; r.an = 4'hF; r.seg = 7'h7F; r.dp = 1'b1;
    rst_n = 1'b1;
    run   = 1'b1;
    exp_q.push_back(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    load_i = 1'b0; digits_i = '0; dp_mask_i = '0; blank_i = '0; brightness_i = 2'd3;
    run = 1'b0; checks = 0; errors = 0;
    repeat (3) @(posedge clk);
    #1;
    release_reset();

    // dark until the first load
    idle(200);

    // basic pattern at full brightness
    wait_phase(20);
    load_now(16'h1234, 4'b0010, 4'b0000);
    idle(2 * FRAME + 10);

    // PWM levels
    brightness_i = 2'd1;
    idle(FRAME);
    brightness_i = 2'd0;
    idle(FRAME);
    brightness_i = 2'd3;

    // overwrite while busy
    wait_phase(10);
    load_now(16'hAAAA, 4'b0000, 4'b0000);
    idle(20);
    load_now(16'h5555, 4'b0000, 4'b0000);
    idle(2 * FRAME);

    // load on the boundary cycle
    wait_phase(30);
    load_now(16'h6789, 4'b1000, 4'b0000);
    wait_phase(FRAME - 1);
    load_now(16'hBCDE, 4'b0101, 4'b0100);
    idle(3 * FRAME);

    // randomized loads, masks and brightness
    repeat (30) begin
      idle($urandom_range(1, 90));
      brightness_i = BR_W'($urandom_range(0, BR_MAX));
      if ($urandom_range(0, 3) != 0)
        load_now(16'($urandom), 4'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
    end
    brightness_i = 2'd3;
    idle(2 * FRAME);

    // asynchronous reset mid-slot with a pending load
    wait_phase(5);
    load_now(16'h8888, 4'b1111, 4'b0000);
    idle(5);
    check("busy_before_reset", {15'd0, busy_o}, 16'h0001);
    @(posedge clk);
    #3;
    run = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    load_q.delete();
    #1;
    check("reset_an", {12'd0, an}, 16'h000F);
    check("reset_seg", {9'd0, seg}, 16'h007F);
    check("reset_dp", {15'd0, dp}, 16'h0001);
    check("reset_busy", {15'd0, busy_o}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    idle(2 * FRAME + 5);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
